ntt_op_sequencer: RTL

Command sequencer between the host op-code port and the 8-PE NTT datapath (`NTT1024` family). It decodes single-cycle `OP_CODE` pulses and runs the matching phase:

- streaming loads of parameters, twiddles and polynomial data;
- forward NTT, inverse NTT and pointwise multiply;
- coefficient read-out.

It drives BRAM write enables and addresses, butterfly issue strobes and stage counters, and signals `done` when a phase ends. It holds no arithmetic; the PE array and BRAMs stay in the datapath.

---
 rtl/ntt_op_sequencer_pkg.sv | 29 ++
 rtl/ntt_op_sequencer_stage.sv | 73 +++++++
 rtl/ntt_op_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_op_sequencer_pkg.sv
// Shared definitions for the NTT op-code sequencer: op codes, FSM states
// and default datapath geometry.
package ntt_op_sequencer_pkg;

    localparam int PE_DEPTH_DEF   = 3;
    localparam int BRAM_DEPTH_DEF = 8;

    localparam logic [4:0] OP_NONE     = 5'd0;
    localparam logic [4:0] OP_LD_PARAM = 5'd1;
    localparam logic [4:0] OP_LD_W     = 5'd2;
    localparam logic [4:0] OP_LD_DATA  = 5'd3;
    localparam logic [4:0] OP_NTT      = 5'd4;
    localparam logic [4:0] OP_INTT     = 5'd7;
    localparam logic [4:0] OP_RD_I     = 5'd8;
    localparam logic [4:0] OP_PWM      = 5'd10;
    localparam logic [4:0] OP_RD_N     = 5'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_P,
        ST_LD_W,
        ST_LD_D,
        ST_RUN,
        ST_DRAIN,
        ST_PWM,
        ST_RD
    } state_e;

endpackage

// File: rtl/ntt_op_sequencer_stage.sv
// Issue/drain counter pair shared by the NTT/INTT and PWM phases.
// While issue_i is high it walks bf_idx through count_i slots; while drain_i
// is high it counts the pipeline drain and bumps the stage at its end.
module ntt_stage_counter #(
    parameter int CW = 10,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          issue_i,
    input  logic          drain_i,
    input  logic [CW-1:0] count_i,
    input  logic [3:0]    stage_limit_i,
    input  logic [LW-1:0] pipe_lat_i,
    output logic          bf_en_o,
    output logic [CW-1:0] bf_idx_o,
    output logic [3:0]    bf_stage_o,
    output logic          issue_end_o,
    output logic          drain_end_o,
    output logic          last_o
);

    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    logic [CW-1:0] idx_q, idx_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [3:0]    stage_q, stage_d;

    assign bf_en_o     = issue_i;
    assign bf_idx_o    = idx_q;
    assign bf_stage_o  = stage_q;
    assign issue_end_o = issue_i && (idx_q == count_i - ONE_C);
    assign drain_end_o = drain_i && (lat_q == pipe_lat_i - ONE_L);
    assign last_o      = drain_end_o && (stage_q == stage_limit_i - 4'd1);

    // Advance the slot counter while issuing and the drain/stage counters while draining.
    always_comb begin
        idx_d   = idx_q;
        lat_d   = lat_q;
        stage_d = stage_q;
        if (clear_i) begin
            idx_d   = '0;
            lat_d   = '0;
            stage_d = '0;
        end else begin
            if (issue_i) begin
                idx_d = issue_end_o ? '0 : idx_q + ONE_C;
            end
            if (drain_i) begin
                lat_d = drain_end_o ? '0 : lat_q + ONE_L;
                if (drain_end_o) begin
                    stage_d = stage_q + 4'd1;
                end
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            lat_q   <= '0;
            stage_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/ntt_op_sequencer.sv
// Command sequencer for the 8-PE NTT datapath: decodes op-code pulses and
// drives BRAM write strobes, butterfly issue and read-out addressing.
module ntt_op_sequencer
    import ntt_op_sequencer_pkg::*;
#(
    parameter int PE_DEPTH   = PE_DEPTH_DEF,
    parameter int BRAM_DEPTH = BRAM_DEPTH_DEF,
    parameter int W_WORDS    = 2552,
    parameter int PIPE_LAT   = 6,
    parameter int MAX_DEPTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            OP_CODE,
    input  logic                  din_valid,
    input  logic [3:0]            ring_depth,
    output logic                  busy,
    output logic                  done,
    output logic                  err_op,
    output logic                  param_we,
    output logic [1:0]            param_sel,
    output logic                  w_we,
    output logic [11:0]           w_addr,
    output logic                  d_we,
    output logic                  d_poly,
    output logic [PE_DEPTH-1:0]   d_pe,
    output logic [BRAM_DEPTH-1:0] d_addr,
    output logic                  bf_en,
    output logic                  bf_inv,
    output logic                  bf_pwm,
    output logic [3:0]            bf_stage,
    output logic [BRAM_DEPTH-1:0] bf_idx,
    output logic                  rd_en,
    output logic [BRAM_DEPTH-1:0] rd_addr
);

    localparam int NW = MAX_DEPTH + 2;
    localparam int CW = MAX_DEPTH - PE_DEPTH + 1;
    localparam int LW = $clog2(PIPE_LAT + 1);
    localparam int JW = PE_DEPTH + BRAM_DEPTH;

    localparam logic [NW-1:0] ONE_N     = NW'(1);
    localparam logic [CW-1:0] ONE_C     = CW'(1);
    localparam logic [NW-1:0] P_LAST    = NW'(2);
    localparam logic [NW-1:0] W_LAST    = NW'(W_WORDS - 1);
    localparam logic [3:0]    DEPTH_MIN = 4'(PE_DEPTH + 1);
    localparam logic [3:0]    DEPTH_MAX = 4'(MAX_DEPTH);
    localparam logic [LW-1:0] LAT_V     = LW'(PIPE_LAT);

    state_e        state_q, state_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] n_q, n_d;
    logic [CW-1:0] g_q, g_d;
    logic [3:0]    depth_q, depth_d;
    logic          inv_q, inv_d;
    logic          pwm_q, pwm_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          opValid;
    logic          depthNeeded;
    logic          depthOk;
    state_e        opState;
    logic [NW-1:0] rdCount;
    logic          polyHi;
    logic [JW-1:0] jIdx;

    logic          scIssue;
    logic          scDrain;
    logic [CW-1:0] scCount;
    logic [3:0]    scLimit;
    logic          scEn;
    logic [CW-1:0] scIdx;
    logic [3:0]    scStage;
    logic          scIssueEnd;
    logic          scDrainEnd;
    logic          scLast;

    assign rdCount = n_q >> PE_DEPTH;
    assign polyHi  = (cnt_q >= n_q);
    assign jIdx    = JW'(polyHi ? cnt_q - n_q : cnt_q);
    assign depthOk = (ring_depth >= DEPTH_MIN) && (ring_depth <= DEPTH_MAX);

    assign scIssue = (state_q == ST_RUN) || (state_q == ST_PWM);
    assign scDrain = (state_q == ST_DRAIN);
    assign scCount = pwm_q ? (g_q << 1) : g_q;
    assign scLimit = pwm_q ? 4'd1 : depth_q;

    ntt_stage_counter #(
        .CW (CW),
        .LW (LW)
    ) u_stage (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (state_q == ST_IDLE),
        .issue_i       (scIssue),
        .drain_i       (scDrain),
        .count_i       (scCount),
        .stage_limit_i (scLimit),
        .pipe_lat_i    (LAT_V),
        .bf_en_o       (scEn),
        .bf_idx_o      (scIdx),
        .bf_stage_o    (scStage),
        .issue_end_o   (scIssueEnd),
        .drain_end_o   (scDrainEnd),
        .last_o        (scLast)
    );

    // Classify the incoming op code: legality, depth check and target state.
    always_comb begin
        opValid     = 1'b1;
        depthNeeded = 1'b1;
        opState     = ST_IDLE;
        case (OP_CODE)
            OP_LD_PARAM: begin opState = ST_LD_P; depthNeeded = 1'b0; end
            OP_LD_W:     begin opState = ST_LD_W; depthNeeded = 1'b0; end
            OP_LD_DATA:  opState = ST_LD_D;
            OP_NTT:      opState = ST_RUN;
            OP_INTT:     opState = ST_RUN;
            OP_PWM:      opState = ST_PWM;
            OP_RD_I:     opState = ST_RD;
            OP_RD_N:     opState = ST_RD;
            default:     opValid = 1'b0;
        endcase
    end

    // Next-state logic: command acceptance in IDLE and phase sequencing elsewhere.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        g_d     = g_q;
        depth_d = depth_q;
        inv_d   = inv_q;
        pwm_d   = pwm_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        if (state_q != ST_IDLE && OP_CODE != OP_NONE) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (OP_CODE != OP_NONE) begin
                    if (!opValid || (depthNeeded && !depthOk)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = opState;
                        n_d     = ONE_N << ring_depth;
                        g_d     = ONE_C << (ring_depth - DEPTH_MIN);
                        depth_d = ring_depth;
                        inv_d   = (OP_CODE == OP_INTT);
                        pwm_d   = (OP_CODE == OP_PWM);
                    end
                end
            end
            ST_LD_P, ST_LD_W, ST_LD_D: begin
                if (din_valid) begin
                    if ((state_q == ST_LD_P && cnt_q == P_LAST) ||
                        (state_q == ST_LD_W && cnt_q == W_LAST) ||
                        (state_q == ST_LD_D && cnt_q == (n_q << 1) - ONE_N)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_N;
                    end
                end
            end
            ST_RUN, ST_PWM: begin
                if (scIssueEnd) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (scLast) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (scDrainEnd) begin
                    state_d = pwm_q ? ST_PWM : ST_RUN;
                end
            end
            ST_RD: begin
                if (cnt_q == rdCount - ONE_N) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE_N;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched command registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            g_q     <= '0;
            depth_q <= '0;
            inv_q   <= 1'b0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            g_q     <= g_d;
            depth_q <= depth_d;
            inv_q   <= inv_d;
            pwm_q   <= pwm_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Output decode: every address is forced to zero unless its strobe is high.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        err_op    = err_q;
        param_we  = (state_q == ST_LD_P) && din_valid;
        param_sel = param_we ? cnt_q[1:0] : 2'd0;
        w_we      = (state_q == ST_LD_W) && din_valid;
        w_addr    = w_we ? 12'(cnt_q) : 12'd0;
        d_we      = (state_q == ST_LD_D) && din_valid;
        d_poly    = d_we && polyHi;
        d_pe      = d_we ? jIdx[PE_DEPTH-1:0] : '0;
        d_addr    = d_we ? jIdx[JW-1:PE_DEPTH] : '0;
        bf_en     = scEn;
        bf_idx    = scEn ? BRAM_DEPTH'(scIdx) : '0;
        bf_stage  = busy ? scStage : 4'd0;
        bf_inv    = inv_q && !pwm_q && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        bf_pwm    = (state_q == ST_PWM);
        rd_en     = (state_q == ST_RD);
        rd_addr   = rd_en ? BRAM_DEPTH'(cnt_q) : '0;
    end

endmodule
